// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path.
//   - Default frame geometry (VGA) and fixed coordinate widths.
//   - Capture FSM state encoding.
//   - RGB565 field positions and the byte-pair packing helper.
package ov7670_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // The camera sends R5G3 first, then G3B5; the first byte is the high half.
  function automatic logic [15:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    w = {hi, lo};
    return {w[RGB_R_MSB:RGB_R_LSB], w[RGB_G_MSB:RGB_G_LSB], w[RGB_B_MSB:RGB_B_LSB]};
  endfunction

endpackage

// File: rtl/ov7670_in_sync.sv
// Synchronizer for the OV7670 parallel bus into the capture clock domain.
//   clk, rst_n                 : capture clock, active-low async reset
//   cam_pclk/vsync/href/data   : raw camera pins (asynchronous)
//   vsync_sync, href_sync      : synchronized levels, aligned with the strobes
//   data_sync                  : byte bus delayed by the same depth as the controls
//   pclk_rise, vsync_rise,
//   vsync_fall, href_fall      : registered one-cycle edge strobes
// A pin edge shows up as a strobe SYNC_STAGES+1 cycles later.
module ov7670_in_sync
  import ov7670_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vsync_sync,
  output logic       href_sync,
  output logic [7:0] data_sync,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  localparam int L = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] pclk_p, vsync_p, href_p;
  logic                   pclk_q, vsync_q, href_q;
  logic [7:0]             data_p [SYNC_STAGES+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_p     <= '0;
      vsync_p    <= '0;
      href_p     <= '0;
      pclk_q     <= 1'b0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      pclk_rise  <= 1'b0;
      vsync_rise <= 1'b0;
      vsync_fall <= 1'b0;
      href_fall  <= 1'b0;
    end else begin
      pclk_p     <= {pclk_p[SYNC_STAGES-2:0], cam_pclk};
      vsync_p    <= {vsync_p[SYNC_STAGES-2:0], cam_vsync};
      href_p     <= {href_p[SYNC_STAGES-2:0], cam_href};
      // Edge stage: strobes and the *_q levels update together so they stay aligned.
      pclk_q     <= pclk_p[L];
      vsync_q    <= vsync_p[L];
      href_q     <= href_p[L];
      pclk_rise  <= pclk_p[L] & ~pclk_q;
      vsync_rise <= vsync_p[L] & ~vsync_q;
      vsync_fall <= ~vsync_p[L] & vsync_q;
      href_fall  <= ~href_p[L] & href_q;
    end
  end

  // Data is stable around the PCLK rising edge, so a plain delay line that
  // matches the control path (including the edge stage) keeps it aligned.
  always_ff @(posedge clk) begin
    data_p[0] <= cam_data;
    for (int i = 1; i <= SYNC_STAGES; i++) data_p[i] <= data_p[i-1];
  end

  assign vsync_sync = vsync_q;
  assign href_sync  = href_q;
  assign data_sync  = data_p[SYNC_STAGES];

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 pixel receiver: oversamples the camera bus in cam_clk, pairs bytes
// into RGB565 pixels with x/y coordinates, and reports framing and errors.
//   cam_clk, resetn            : sole clock, active-low async reset (sync release)
//   capture_en                 : level-sensitive arm
//   cam_pclk/vsync/href/data   : camera parallel bus (PCLK <= cam_clk/4)
//   pix_valid/data/x/y         : pixel strobe, RGB565 word, coordinates
//   frame_start, frame_done    : framing strobes
//   line_err, frame_err        : sticky errors, cleared at frame_start
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic           cam_clk,
  input  logic           resetn,
  input  logic           capture_en,
  input  logic           cam_pclk,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  output logic           pix_valid,
  output logic [15:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           line_err,
  output logic           frame_err
);

  localparam logic [X_W-1:0] H_MAX = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_ACTIVE);

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (v >= V_MAX) ? v : v + 1'b1;
  endfunction

  // Reset assertion is immediate; release is retimed to cam_clk.
  logic [1:0] rst_chain;
  logic       rst_n;

  always_ff @(posedge cam_clk or negedge resetn) begin
    if (!resetn) rst_chain <= 2'b00;
    else         rst_chain <= {rst_chain[0], 1'b1};
  end

  assign rst_n = rst_chain[1];

  logic       vsync_s, href_s, pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic [7:0] data_s;

  ov7670_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (cam_clk),
    .rst_n      (rst_n),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .vsync_sync (vsync_s),
    .href_sync  (href_s),
    .data_sync  (data_s),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  cap_state_t     state, state_nxt;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y, y_closed, y_end;
  logic           phase;
  logic [7:0]     hi_byte;
  logic           start_evt, done_evt, line_close, byte_evt, in_window;

  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (capture_en && vsync_s) state_nxt = WAIT_VS;
      WAIT_VS: if (!capture_en)           state_nxt = IDLE;
               else if (vsync_fall)       state_nxt = ACTIVE;
      ACTIVE:  if (vsync_rise)            state_nxt = DONE;
      DONE:    state_nxt = capture_en ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_evt  = (state == WAIT_VS) && capture_en && vsync_fall;
    done_evt   = (state == ACTIVE) && vsync_rise;
    // A line still open when VSYNC rises is closed exactly like an HREF fall.
    line_close = (state == ACTIVE) && (href_fall || (vsync_rise && href_s));
    // Bytes coinciding with the end of frame are ignored so frame_done never
    // lands on a pixel strobe.
    byte_evt   = (state == ACTIVE) && pclk_rise && href_s && !vsync_rise;
    in_window  = (x < H_MAX) && (y < V_MAX);
    y_closed   = sat_inc_y(y);
    y_end      = line_close ? y_closed : y;
  end

  // Byte-pairing / counter stage
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= start_evt;
      frame_done  <= done_evt;
      if (start_evt) begin
        x         <= '0;
        y         <= '0;
        phase     <= 1'b0;
        line_err  <= 1'b0;
        frame_err <= 1'b0;
      end else if (state == ACTIVE) begin
        if (line_close) begin
          if (phase || (x != H_MAX)) line_err <= 1'b1;
          x     <= '0;
          phase <= 1'b0;
          y     <= y_closed;
        end else if (byte_evt) begin
          phase <= ~phase;
          if (x >= H_MAX) line_err  <= 1'b1;
          if (y >= V_MAX) frame_err <= 1'b1;
          if (phase && in_window) begin
            pix_valid <= 1'b1;
            pix_data  <= pack_rgb565(hi_byte, data_s);
            pix_x     <= x;
            pix_y     <= y;
            x         <= x + 1'b1;
          end
        end
        if (vsync_rise && (y_end != V_MAX)) frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge cam_clk) begin
    if (byte_evt && !phase) hi_byte <= data_s;
  end

endmodule

// File: tb/tb_ov7670_capture.sv
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 3;

  logic        cam_clk    = 1'b0;
  logic        resetn     = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_pclk   = 1'b0;
  logic        cam_vsync  = 1'b0;
  logic        cam_href   = 1'b0;
  logic [7:0]  cam_data   = 8'h00;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        frame_start, frame_done, line_err, frame_err;
  logic [39:0] outs;

  typedef struct packed {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
  } pix_t;

  pix_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;

  always #5 cam_clk = ~cam_clk;

  assign outs = {pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err, frame_err};

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
    .cam_clk     (cam_clk),
    .resetn      (resetn),
    .capture_en  (capture_en),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_err   (frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, req);
    end
  endtask

  // One PCLK period = 4 cam_clk cycles; bus changes on the PCLK falling edge.
  task automatic pcyc(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge cam_clk); cam_pclk = 1'b0; cam_vsync = vs; cam_href = hr; cam_data = d;
    @(negedge cam_clk);
    @(negedge cam_clk); cam_pclk = 1'b1;
    @(negedge cam_clk);
  endtask

  task automatic blank(input logic vs, input int n);
    repeat (n) pcyc(vs, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] base, input int row);
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] v;
      pix_t p;
      v = base + 8'(b);
      if (b[0] && (b / 2) < H) begin
        p.d = {v - 8'd1, v};
        p.x = 10'(b / 2);
        p.y = 9'(row);
        exp_q.push_back(p);
      end
      pcyc(1'b0, 1'b1, v);
    end
    blank(1'b0, 2);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge cam_clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Output monitor / scoreboard consumer
  initial begin
    pix_t e;
    forever begin
      @(posedge cam_clk); #1;
      if (frame_start) fs_cnt++;
      if (frame_done)  fd_cnt++;
      if (frame_start || frame_done) chk("strobe_vs_pix", pix_valid, 0);
      if (pix_valid) begin
        chk("pix_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pix", {pix_data, pix_x, pix_y}, e);
        end
      end
    end
  end

  initial begin
    // Reset held while the camera bus toggles
    for (int i = 0; i < 6; i++) begin
      pcyc(i[0], i[1], 8'($urandom));
      chk("reset_outs", outs, 0);
    end
    @(negedge cam_clk); resetn = 1'b1;

    // Not armed, or armed with VSYNC low: no frame starts
    blank(1'b1, 4); blank(1'b0, 4);
    chk("idle_no_arm", fs_cnt, 0);
    capture_en = 1'b1;
    blank(1'b0, 4);
    chk("idle_vs_low", fs_cnt, 0);
    blank(1'b1, 3);
    chk("armed_wait", fs_cnt, 0);
    blank(1'b0, 3);
    chk("frame_start1", fs_cnt, 1);
    chk("flags_at_start", {line_err, frame_err}, 0);

    // Full 4x3 frame, bytes 0x00..0x17
    for (int r = 0; r < V; r++) send_line(8, 8'(8 * r), r);
    blank(1'b1, 4);
    drain("drain_4x3");
    chk("frame_done1", fd_cnt, 1);
    chk("errs_4x3", {line_err, frame_err}, 0);
    chk("last_pix", {pix_data, pix_x, pix_y}, {16'h1617, 10'd3, 9'd2});

    // Odd-length line, then normal lines
    blank(1'b0, 3);
    chk("frame_start2", fs_cnt, 2);
    send_line(7, 8'h40, 0);
    drain("drain_odd");
    chk("odd_line_err", line_err, 1);
    chk("odd_pix_x", pix_x, 2);
    send_line(8, 8'h50, 1);
    send_line(8, 8'h60, 2);
    blank(1'b1, 4);
    drain("drain_after_odd");
    chk("odd_frame_err", frame_err, 0);
    chk("line_err_sticky", line_err, 1);
    chk("frame_done2", fd_cnt, 2);

    // Short frame: two lines of three
    blank(1'b0, 3);
    chk("frame_start3", fs_cnt, 3);
    chk("start_clears_line_err", line_err, 0);
    send_line(8, 8'h70, 0);
    send_line(8, 8'h78, 1);
    blank(1'b1, 4);
    drain("drain_short");
    chk("short_frame_err", frame_err, 1);
    chk("frame_done3", fd_cnt, 3);

    // Next frame clears flags; disarm after the first line
    blank(1'b0, 3);
    chk("frame_start4", fs_cnt, 4);
    chk("start_clears_frame_err", frame_err, 0);
    send_line(8, 8'h80, 0);
    capture_en = 1'b0;
    send_line(8, 8'h88, 1);
    send_line(8, 8'h90, 2);
    blank(1'b1, 4);
    drain("drain_disarm");
    chk("frame_done_disarm", fd_cnt, 4);
    chk("disarm_errs", {line_err, frame_err}, 0);
    blank(1'b0, 4); blank(1'b1, 2); blank(1'b0, 4);
    chk("no_start_disarmed", fs_cnt, 4);

    // Reset pulsed mid-line
    capture_en = 1'b1;
    blank(1'b1, 3); blank(1'b0, 3);
    chk("frame_start5", fs_cnt, 5);
    begin
      pix_t p;
      p = {16'hA0A1, 10'd0, 9'd0}; exp_q.push_back(p);
      p = {16'hA2A3, 10'd1, 9'd0}; exp_q.push_back(p);
    end
    for (int b = 0; b < 4; b++) pcyc(1'b0, 1'b1, 8'hA0 + 8'(b));
    drain("drain_pre_reset");
    chk("pre_reset_x", pix_x, 1);
    @(negedge cam_clk); resetn = 1'b0;
    #1;
    chk("reset_async_outs", outs, 0);
    pcyc(1'b0, 1'b1, 8'hA4);
    pcyc(1'b0, 1'b1, 8'hA5);
    chk("reset_hold_outs", outs, 0);
    @(negedge cam_clk); resetn = 1'b1;
    pcyc(1'b0, 1'b1, 8'hA6);
    pcyc(1'b0, 1'b1, 8'hA7);
    blank(1'b0, 2);
    blank(1'b1, 4);
    chk("no_done_after_reset", fd_cnt, 4);
    blank(1'b0, 3);
    chk("frame_start6", fs_cnt, 6);
    send_line(8, 8'hB0, 0);
    drain("drain_resume");
    chk("resume_xy", {pix_x, pix_y}, {10'd3, 9'd0});
    blank(1'b1, 4);
    chk("frame_done_resume", fd_cnt, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
